// File: rtl/radiant_trig_holdoff.sv
// -----------------------------------------------------------------------------
// radiant_trig_holdoff
//
// Turns the coincidence level from radiant_trigger into a fixed-width trigger
// pulse, then holds the block busy for a programmable deadtime and until the
// readout acknowledges. Rising edges that arrive while busy are counted as
// vetoes; accepted edges are counted as triggers. Both counters saturate.
//
// Ports
//   trig_clk_i    in   1              trigger clock, the block's only clock
//   rst_n_i       in   1              asynchronous active-low reset
//   trigger_i     in   1              coincidence level, synchronous to trig_clk_i
//   enable_i      in   1              new triggers accepted while high
//   pulse_len_i   in   4              output pulse length minus 1, in clocks
//   holdoff_i     in   HOLDOFF_WIDTH  deadtime after the pulse, in clocks
//   ack_i         in   1              readout acknowledge, level-sensitive
//   count_clr_i   in   1              synchronous clear of both counters
//   trig_o        out  1              registered trigger pulse
//   busy_o        out  1              high whenever the sequencer is not idle
//   trig_count_o  out  COUNT_WIDTH    accepted triggers (saturating)
//   veto_count_o  out  COUNT_WIDTH    triggers rejected while busy (saturating)
// -----------------------------------------------------------------------------
module radiant_trig_holdoff #(
    parameter int COUNT_WIDTH   = 32,
    parameter int HOLDOFF_WIDTH = 16
) (
    input  logic                     trig_clk_i,
    input  logic                     rst_n_i,
    input  logic                     trigger_i,
    input  logic                     enable_i,
    input  logic [3:0]               pulse_len_i,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff_i,
    input  logic                     ack_i,
    input  logic                     count_clr_i,
    output logic                     trig_o,
    output logic                     busy_o,
    output logic [COUNT_WIDTH-1:0]   trig_count_o,
    output logic [COUNT_WIDTH-1:0]   veto_count_o
);

    // One down-counter serves both the pulse and the holdoff phases, so it
    // must be wide enough for whichever length is larger.
    localparam int CNT_W = (HOLDOFF_WIDTH > 4) ? HOLDOFF_WIDTH : 4;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        HOLDOFF,
        WAIT_ACK
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             t_q, t_qq;
    logic             rise;
    logic             accept;
    logic             veto;

    // Edge detector. Both stages reset high so a trigger_i already high at
    // reset release is not seen as an edge; a low must be observed first.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; blocking = here would chain t_q straight into t_qq.
    always_ff @(posedge trig_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            t_q  <= 1'b1;
            t_qq <= 1'b1;
        end else begin
            t_q  <= trigger_i;
            t_qq <= t_q;
        end
    end

    assign rise = t_q & ~t_qq;

    // Any enabled edge seen while not idle is a veto, including one landing
    // in the same clock that WAIT_ACK returns to IDLE.
    assign veto = rise & enable_i & (state_q != IDLE);

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rise && enable_i) begin
                    accept  = 1'b1;
                    state_d = PULSE;
                    cnt_d   = CNT_W'(pulse_len_i);
                end
            end

            // Counter holds pulse_len..0, giving pulse_len+1 PULSE cycles.
            PULSE: begin
                if (cnt_q == '0) begin
                    if (holdoff_i != '0) begin
                        state_d = HOLDOFF;
                        cnt_d   = CNT_W'(holdoff_i);
                    end else begin
                        state_d = WAIT_ACK;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            // Counter holds holdoff..1, giving exactly holdoff cycles here.
            HOLDOFF: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = WAIT_ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            WAIT_ACK: begin
                if (ack_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: reset clears every flop asynchronously, so a reset mid-sequence
    // drops trig_o and busy_o in the same cycle without waiting for a clock.
    always_ff @(posedge trig_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            trig_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Registered copy of the PULSE state: trig_o rises one clock after
            // PULSE is entered, two after the edge that sampled trigger_i high.
            trig_o  <= (state_q == PULSE);
        end
    end

    assign busy_o = (state_q != IDLE);

    // Saturating event counters; a clear wins over a same-cycle increment.
    always_ff @(posedge trig_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            trig_count_o <= '0;
            veto_count_o <= '0;
        end else if (count_clr_i) begin
            trig_count_o <= '0;
            veto_count_o <= '0;
        end else begin
            if (accept && (trig_count_o != '1)) begin
                trig_count_o <= trig_count_o + 1'b1;
            end
            if (veto && (veto_count_o != '1)) begin
                veto_count_o <= veto_count_o + 1'b1;
            end
        end
    end

endmodule

// File: doc/radiant_trig_holdoff.md
RADIANT_TRIG_HOLDOFF -- requirements
Module: radiant_trig_holdoff

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 32, the width of each event counter.
REQ-002 SHALL have parameter HOLDOFF_WIDTH, default 16, the width of the holdoff length.
REQ-003 SHALL have port trig_clk_i  input  1  400 MHz trigger clock; the block's only clock.
REQ-004 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port trigger_i  input  1  coincidence level from the upstream radiant_trigger, synchronous to trig_clk_i.
REQ-006 SHALL have port enable_i  input  1  accepts new triggers while high.
REQ-007 SHALL have port pulse_len_i  input  4  output pulse length minus 1, in clocks.
REQ-008 SHALL have port holdoff_i  input  HOLDOFF_WIDTH  deadtime after the pulse, in clocks.
REQ-009 SHALL have port ack_i  input  1  readout acknowledge, level-sensitive.
REQ-010 SHALL have port count_clr_i  input  1  synchronous clear of both counters.
REQ-011 SHALL have port trig_o  output  1  registered fixed-width trigger pulse.
REQ-012 SHALL have port busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-013 SHALL have port trig_count_o  output  COUNT_WIDTH  count of accepted triggers.
REQ-014 SHALL have port veto_count_o  output  COUNT_WIDTH  count of triggers rejected while busy.

Function
REQ-015 SHALL register trigger_i into t_q, then t_q into t_qq; rising edge = t_q & ~t_qq.
REQ-016 SHALL implement the FSM states IDLE, PULSE, HOLDOFF and WAIT_ACK.
REQ-017 SHALL, in IDLE with enable_i=1 and a rising edge, go to PULSE on the next clock, load the pulse counter with pulse_len_i, and increment trig_count_o.
REQ-018 SHALL drive trig_o high for exactly the PULSE-state cycles: asserted 2 clocks after the first clock edge that samples trigger_i high, and held for pulse_len_i+1 clocks.
REQ-019 SHALL sample pulse_len_i and holdoff_i only when entering PULSE and HOLDOFF respectively; changes at other times have no effect on the current sequence.
REQ-020 SHALL leave PULSE when the pulse counter reaches 0: to HOLDOFF with counter=holdoff_i if holdoff_i≠0, else directly to WAIT_ACK.
REQ-021 SHALL stay in HOLDOFF for exactly holdoff_i clocks, then go to WAIT_ACK.
REQ-022 SHALL leave WAIT_ACK for IDLE on the first clock where ack_i=1; an ack_i already high on entry gives 1 WAIT_ACK cycle.
REQ-023 SHALL ignore ack_i outside WAIT_ACK.
REQ-024 SHALL increment veto_count_o by 1 for each rising edge with enable_i=1 while the FSM is not IDLE.
REQ-025 SHALL neither count nor act on rising edges with enable_i=0.
REQ-026 SHALL complete an in-progress sequence if enable_i falls mid-sequence.
REQ-027 SHALL treat trigger_i held high as a single edge; a new edge requires trigger_i low for at least 1 clock.
REQ-028 SHALL saturate both counters at all-ones, with no wrap.
REQ-029 SHALL give count_clr_i priority over a same-cycle increment: the counter reads 0 on the next clock.
REQ-030 SHALL accept a rising edge in the same clock that the FSM returns to IDLE only from the following clock; that edge, if enable_i=1, counts as a veto.

Reset
REQ-031 SHALL, on rst_n_i=0, asynchronously force FSM=IDLE, trig_o=0, busy_o=0, trig_count_o=0, veto_count_o=0, internal counters=0, t_q=1 and t_qq=1.
REQ-032 SHALL NOT produce an edge or trigger when trigger_i is held high across reset release; it first requires a low.
REQ-033 SHALL, on reset mid-sequence, abort immediately to IDLE with trig_o low in the same cycle.

Verification
REQ-034 SHALL verify: enable=1, pulse_len=3, holdoff=10, ack tied high, 1-cycle trigger_i pulse -> trig_o high 4 clocks starting 2 clocks after the sample, busy_o high 4+10+1=15 clocks, trig_count=1, veto_count=0.
REQ-035 SHALL verify: second trigger_i pulse during HOLDOFF, then a third after IDLE -> veto_count=1, trig_count=2, only two trig_o pulses.
REQ-036 SHALL verify: holdoff=0, ack_i low for 20 clocks after the pulse and then high -> busy_o stays high until the clock after ack_i rises, no HOLDOFF cycles.
REQ-037 SHALL verify: trigger_i high through and after rst_n_i release -> no trig_o, counts 0; trigger_i low then high -> 1 trigger.
REQ-038 SHALL verify: trig_count preloaded to all-ones minus 1 via 2^COUNT_WIDTH-2 triggers (COUNT_WIDTH=4 build), 3 more triggers -> holds at 15; count_clr_i coincident with a trigger -> 0.
REQ-039 SHALL verify: rst_n_i asserted during PULSE -> trig_o and busy_o low immediately, FSM IDLE, counters 0.
